cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Micro-sequencer for the 8-bit teaching CPU; drives fetch/decode/execute of every instruction in the ISA.
- Sits between the instruction decoder (one-hot instruction vector) and the datapath (PC, MAR, IR, register file, ALU, flag register, I/O port).
- Latches the one-hot vector in DECODE, then steps the datapath through 1-3 execute states and produces per-state control strobes.
- Handles run/stop, HALT and illegal opcodes.

Parameters:
- INSTR_W, 16, width of one-hot instruction vector; fixed order in package.
- ALU_OP_W, 3, width of alu_op.
- HALT_RESUME, 0, 1 = a start pulse in HALT resumes fetch; 0 = only reset leaves HALT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE (and HALT if HALT_RESUME=1).
- run  in  1  level; 0 = stop at next instruction boundary.
- instr  in  INSTR_W  one-hot decoder output, valid while dec_en=1.
- z_flag  in  1  registered zero flag.
- c_flag  in  1  registered carry flag.
- dec_en  out  1  decoder enable.
- mar_ld_pc  out  1  MAR <= PC.
- mar_ld_bus  out  1  MAR <= memory data (operand address).
- mem_rd  out  1  memory read.
- mem_wr  out  1  memory write.
- ir_ld  out  1  IR <= memory data.
- pc_inc  out  1  PC <= PC+1.
- pc_ld  out  1  PC <= memory data.
- reg_we  out  1  register-file write (dest = IR[3:2]).
- reg_src_mem  out  1  write data from memory (1) or ALU/input port (0).
- alu_op  out  ALU_OP_W  ALU function.
- flags_we  out  1  flag register update.
- in_en  out  1  input port onto write path.
- out_en  out  1  output port latch from reg IR[1:0].
- halted  out  1  in HALT.
- illegal  out  1  one-cycle pulse on zero/multi-hot instr.

Behaviour:
- Async reset: state = IDLE, instr_q = 0, every output 0.
- States: IDLE, F1, F2, DEC, EX1, EX2, EX3, HALT. Unlisted strobes are 0 in every state.
- Control outputs are combinational from state and instr_q. The only exception is pc_ld/pc_inc in jump EX2, which also depend on z_flag/c_flag.
- IDLE: start=1 and run=1 -> F1; otherwise stay.
- F1: mar_ld_pc=1 -> F2.
- F2: mem_rd=1, ir_ld=1, pc_inc=1 -> DEC.
- DEC: dec_en=1; instr_q <= instr.
  - Zero-hot or multi-hot: illegal pulses, instr_q treated as nop.
  - halt -> HALT; otherwise -> EX1.
- EX1 for ALU-class instructions: reg_we=1, flags_we=1, alu_op = ADD 0 / SUB 1 / AND 2 / NOT 3 / SHR 4 / SHL 5.
- EX1 for mova: alu_op=PASS 6, reg_we=1, flags_we=0.
- EX1 for in1: in_en=1, reg_we=1. For out1: out_en=1. For nop: no strobes.
- All of the above finish in 4 cycles: F1, F2, DEC, EX1.
- EX1 for movb/movc/jmp/jz/jc: mar_ld_pc=1 -> EX2.
- Jumps, EX2: mem_rd=1; taken -> pc_ld=1, not taken -> pc_inc=1. Total 5 cycles.
  - jmp: always taken. jz: taken when z_flag=1. jc: taken when c_flag=1.
  - Flags are sampled in EX2.
- movb/movc, EX2: mem_rd=1, mar_ld_bus=1, pc_inc=1 -> EX3.
- movb/movc, EX3: total 6 cycles.
  - movb (store): mem_wr=1.
  - movc (load): mem_rd=1, reg_we=1, reg_src_mem=1.
- Boundary after the last execute state: run=1 -> F1; run=0 -> IDLE. run is ignored mid-instruction.
- HALT: halted=1; instr_q held.
  - HALT_RESUME=1: start -> F1.
  - HALT_RESUME=0: stays until reset.
- start while not in IDLE/HALT is ignored.
- Reset mid-instruction: immediate IDLE, no further strobes.
- mem_rd and mem_wr are never both 1. pc_ld and pc_inc are never both 1.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum;
  - instruction-vector bit indices, MSB-first: mova=15, movb, movc, add, sub, and1, not1, rsr, rsl, jmp, jz, jc, in1, out1, nop, halt=0;
  - ALU_OP_* constants.
- No sub-module required; the single FSM with output decode fits in one file.

Test Plan:
- Reset then start with instr=add (bit 12) in DEC -> F1..EX1 = 4 cycles; EX1 has reg_we=1, flags_we=1, alu_op=0; returns to F1 with run=1.
- jz with z_flag=1 -> EX2 pc_ld=1, pc_inc=0. Repeat with z_flag=0 -> pc_inc=1, pc_ld=0. Instruction takes 5 cycles.
- movb -> EX2 asserts mar_ld_bus=1 and pc_inc=1; EX3 asserts mem_wr=1 and mem_rd=0; 6 cycles total.
- instr=16'h0000, then instr=16'h0300, in DEC -> illegal pulses 1 cycle; sequence behaves as nop (4 cycles, no strobes in EX1).
- halt (bit 0) -> HALT, halted=1.
  - HALT_RESUME=0: start ignored for 10 cycles.
  - HALT_RESUME=1: start -> F1 next cycle.
- run drops during movc EX2 -> EX3 completes with reg_we=1, then IDLE. Also: rst_n low in EX2 -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the teaching-CPU micro-sequencer.
// Instruction bit indices follow the decoder's one-hot order, MSB-first.
package cpu_ctrl_pkg;

    localparam int CPU_INSTR_W  = 16;
    localparam int CPU_ALU_OP_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_DEC,
        S_EX1,
        S_EX2,
        S_EX3,
        S_HALT
    } state_t;

    localparam int I_MOVA = 15;
    localparam int I_MOVB = 14;
    localparam int I_MOVC = 13;
    localparam int I_ADD  = 12;
    localparam int I_SUB  = 11;
    localparam int I_AND1 = 10;
    localparam int I_NOT1 = 9;
    localparam int I_RSR  = 8;
    localparam int I_RSL  = 7;
    localparam int I_JMP  = 6;
    localparam int I_JZ   = 5;
    localparam int I_JC   = 4;
    localparam int I_IN1  = 3;
    localparam int I_OUT1 = 2;
    localparam int I_NOP  = 1;
    localparam int I_HALT = 0;

    localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_ADD  = 3'd0;
    localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_SUB  = 3'd1;
    localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_AND  = 3'd2;
    localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_NOT  = 3'd3;
    localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_SHR  = 3'd4;
    localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_SHL  = 3'd5;
    localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_PASS = 3'd6;

    function automatic logic is_onehot(input logic [CPU_INSTR_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Fetch/decode/execute micro-sequencer: latches the decoded instruction and
// emits per-state datapath strobes for 1-3 execute states.
//
// state  | meaning
// IDLE   | stopped, waiting for start with run=1
// F1     | MAR <= PC
// F2     | read memory into IR, PC++
// DEC    | decoder enabled, instruction latched
// EX1    | ALU/move/IO work, or MAR <= PC for operand fetch
// EX2    | jump resolve, or operand address load for movb/movc
// EX3    | movb store / movc load
// HALT   | stopped after halt instruction
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int INSTR_W     = CPU_INSTR_W,
    parameter int ALU_OP_W    = CPU_ALU_OP_W,
    parameter int HALT_RESUME = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                run,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                z_flag,
    input  logic                c_flag,
    output logic                dec_en,
    output logic                mar_ld_pc,
    output logic                mar_ld_bus,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                reg_we,
    output logic                reg_src_mem,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                flags_we,
    output logic                in_en,
    output logic                out_en,
    output logic                halted,
    output logic                illegal
);

    state_t               state;
    logic [INSTR_W-1:0]   instr_q;
    state_t               next_bnd;
    logic                 is_jump;
    logic                 is_mov;
    logic                 taken;
    logic [2:0]           alu_c;

    assign next_bnd = run ? S_F1 : S_IDLE;
    assign is_jump  = instr_q[I_JMP] | instr_q[I_JZ] | instr_q[I_JC];
    assign is_mov   = instr_q[I_MOVB] | instr_q[I_MOVC];
    assign taken    = instr_q[I_JMP] | (instr_q[I_JZ] & z_flag) | (instr_q[I_JC] & c_flag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            instr_q <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE: if (start && run) state <= S_F1;
                S_F1:   state <= S_F2;
                S_F2:   state <= S_DEC;
                S_DEC: begin
                    // Malformed vectors (including ones carrying the halt bit) run as nop.
                    if (!is_onehot(instr[CPU_INSTR_W-1:0])) begin
                        instr_q        <= '0;
                        instr_q[I_NOP] <= 1'b1;
                        illegal        <= 1'b1;
                        state          <= S_EX1;
                    end else begin
                        instr_q <= instr;
                        state   <= instr[I_HALT] ? S_HALT : S_EX1;
                    end
                end
                S_EX1:  state <= (is_jump || is_mov) ? S_EX2 : next_bnd;
                S_EX2:  state <= is_mov ? S_EX3 : next_bnd;
                S_EX3:  state <= next_bnd;
                S_HALT: if ((HALT_RESUME != 0) && start) state <= S_F1;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dec_en      = 1'b0;
        mar_ld_pc   = 1'b0;
        mar_ld_bus  = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ir_ld       = 1'b0;
        pc_inc      = 1'b0;
        pc_ld       = 1'b0;
        reg_we      = 1'b0;
        reg_src_mem = 1'b0;
        alu_c       = ALU_OP_ADD;
        flags_we    = 1'b0;
        in_en       = 1'b0;
        out_en      = 1'b0;
        halted      = 1'b0;
        case (state)
            S_F1: mar_ld_pc = 1'b1;
            S_F2: begin
                mem_rd = 1'b1;
                ir_ld  = 1'b1;
                pc_inc = 1'b1;
            end
            S_DEC: dec_en = 1'b1;
            S_EX1: begin
                if (instr_q[I_ADD] | instr_q[I_SUB] | instr_q[I_AND1] |
                    instr_q[I_NOT1] | instr_q[I_RSR] | instr_q[I_RSL]) begin
                    reg_we   = 1'b1;
                    flags_we = 1'b1;
                    if (instr_q[I_SUB])       alu_c = ALU_OP_SUB;
                    else if (instr_q[I_AND1]) alu_c = ALU_OP_AND;
                    else if (instr_q[I_NOT1]) alu_c = ALU_OP_NOT;
                    else if (instr_q[I_RSR])  alu_c = ALU_OP_SHR;
                    else if (instr_q[I_RSL])  alu_c = ALU_OP_SHL;
                    else                      alu_c = ALU_OP_ADD;
                end else if (instr_q[I_MOVA]) begin
                    reg_we = 1'b1;
                    alu_c  = ALU_OP_PASS;
                end else if (instr_q[I_IN1]) begin
                    in_en  = 1'b1;
                    reg_we = 1'b1;
                end else if (instr_q[I_OUT1]) begin
                    out_en = 1'b1;
                end else if (is_jump || is_mov) begin
                    mar_ld_pc = 1'b1;
                end
            end
            S_EX2: begin
                mem_rd = 1'b1;
                if (is_jump) begin
                    pc_ld  = taken;
                    pc_inc = ~taken;
                end else begin
                    mar_ld_bus = 1'b1;
                    pc_inc     = 1'b1;
                end
            end
            S_EX3: begin
                if (instr_q[I_MOVB]) begin
                    mem_wr = 1'b1;
                end else if (instr_q[I_MOVC]) begin
                    mem_rd      = 1'b1;
                    reg_we      = 1'b1;
                    reg_src_mem = 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign alu_op = ALU_OP_W'(alu_c);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized bench for cpu_ctrl_fsm: two instances (halt-resume off/on) compared
// cycle by cycle against a per-instruction strobe table.
module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        run;
    logic [15:0] instr;
    logic        z_flag;
    logic        c_flag;

    logic dec_en0, mar_ld_pc0, mar_ld_bus0, mem_rd0, mem_wr0, ir_ld0, pc_inc0, pc_ld0;
    logic reg_we0, reg_src_mem0, flags_we0, in_en0, out_en0, halted0, illegal0;
    logic [2:0] alu_op0;
    logic dec_en1, mar_ld_pc1, mar_ld_bus1, mem_rd1, mem_wr1, ir_ld1, pc_inc1, pc_ld1;
    logic reg_we1, reg_src_mem1, flags_we1, in_en1, out_en1, halted1, illegal1;
    logic [2:0] alu_op1;
    logic [17:0] obs0, obs1;

    int total = 0;
    int bad   = 0;
    bit last_run;

    cpu_ctrl_fsm #(.INSTR_W(16), .ALU_OP_W(3), .HALT_RESUME(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .run(run), .instr(instr),
        .z_flag(z_flag), .c_flag(c_flag),
        .dec_en(dec_en0), .mar_ld_pc(mar_ld_pc0), .mar_ld_bus(mar_ld_bus0),
        .mem_rd(mem_rd0), .mem_wr(mem_wr0), .ir_ld(ir_ld0), .pc_inc(pc_inc0),
        .pc_ld(pc_ld0), .reg_we(reg_we0), .reg_src_mem(reg_src_mem0),
        .alu_op(alu_op0), .flags_we(flags_we0), .in_en(in_en0), .out_en(out_en0),
        .halted(halted0), .illegal(illegal0)
    );

    cpu_ctrl_fsm #(.INSTR_W(16), .ALU_OP_W(3), .HALT_RESUME(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .run(run), .instr(instr),
        .z_flag(z_flag), .c_flag(c_flag),
        .dec_en(dec_en1), .mar_ld_pc(mar_ld_pc1), .mar_ld_bus(mar_ld_bus1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .ir_ld(ir_ld1), .pc_inc(pc_inc1),
        .pc_ld(pc_ld1), .reg_we(reg_we1), .reg_src_mem(reg_src_mem1),
        .alu_op(alu_op1), .flags_we(flags_we1), .in_en(in_en1), .out_en(out_en1),
        .halted(halted1), .illegal(illegal1)
    );

    // bit 17 dec_en .. bit 8 reg_src_mem, [7:5] alu_op, 4 flags_we, 3 in, 2 out, 1 halted, 0 illegal
    assign obs0 = {dec_en0, mar_ld_pc0, mar_ld_bus0, mem_rd0, mem_wr0, ir_ld0, pc_inc0, pc_ld0,
                   reg_we0, reg_src_mem0, alu_op0, flags_we0, in_en0, out_en0, halted0, illegal0};
    assign obs1 = {dec_en1, mar_ld_pc1, mar_ld_bus1, mem_rd1, mem_wr1, ir_ld1, pc_inc1, pc_ld1,
                   reg_we1, reg_src_mem1, alu_op1, flags_we1, in_en1, out_en1, halted1, illegal1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // idx = instruction bit (mova=15 .. halt=0), -1 = zero/multi-hot vector
    function automatic int n_cycles(input int idx);
        case (idx)
            14, 13:    return 6;
            6, 5, 4:   return 5;
            default:   return 4;
        endcase
    endfunction

    // Expected strobes in cycle k (0 = F1) of an instruction.
    function automatic logic [17:0] exp_vec(input int idx, input int k, input bit z, input bit c);
        logic [17:0] v;
        bit tk;
        v = '0;
        if (k == 0) v[16] = 1'b1;
        else if (k == 1) begin v[14] = 1'b1; v[12] = 1'b1; v[11] = 1'b1; end
        else if (k == 2) v[17] = 1'b1;
        else if (idx == 0) v[1] = 1'b1;
        else if (k == 3) begin
            case (idx)
                -1: v[0] = 1'b1;
                15: begin v[9] = 1'b1; v[7:5] = 3'd6; end
                12, 11, 10, 9, 8, 7: begin v[9] = 1'b1; v[4] = 1'b1; v[7:5] = 3'(12 - idx); end
                3: begin v[3] = 1'b1; v[9] = 1'b1; end
                2: v[2] = 1'b1;
                14, 13, 6, 5, 4: v[16] = 1'b1;
                default: ;
            endcase
        end else if (k == 4) begin
            v[14] = 1'b1;
            if (idx == 6 || idx == 5 || idx == 4) begin
                tk = (idx == 6) || (idx == 5 && z) || (idx == 4 && c);
                if (tk) v[10] = 1'b1;
                else    v[11] = 1'b1;
            end else begin
                v[15] = 1'b1;
                v[11] = 1'b1;
            end
        end else if (k == 5) begin
            if (idx == 14) v[13] = 1'b1;
            else begin v[14] = 1'b1; v[9] = 1'b1; v[8] = 1'b1; end
        end
        return v;
    endfunction

    task automatic run_instr(input int idx, input logic [15:0] vec, input bit z, input bit c,
                             input bit run_final);
        int n;
        logic [17:0] e;
        instr  = vec;
        z_flag = z;
        c_flag = c;
        if (!last_run) begin
            @(negedge clk);
            check_eq("idle0", 32'(obs0), 32'd0);
            check_eq("idle1", 32'(obs1), 32'd0);
            start = 1'b1;
            run   = 1'b1;
        end
        n = n_cycles(idx);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e = exp_vec(idx, k, z, c);
            check_eq($sformatf("d0 i%0d cyc%0d", idx, k), 32'(obs0), 32'(e));
            check_eq($sformatf("d1 i%0d cyc%0d", idx, k), 32'(obs1), 32'(e));
            if (k == n - 1) begin
                start = 1'b0;
                run   = run_final;
            end else begin
                start = 1'($urandom_range(0, 1));
                run   = 1'($urandom_range(0, 1));
            end
        end
        last_run = run_final;
    endtask

    initial begin
        int r, b0, b1;
        logic [15:0] v;
        rst_n = 1'b0; start = 1'b0; run = 1'b0; instr = '0; z_flag = 1'b0; c_flag = 1'b0;
        last_run = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset0", 32'(obs0), 32'd0);
        check_eq("reset1", 32'(obs1), 32'd0);
        rst_n = 1'b1;

        run_instr(12, 16'h1000, 0, 0, 1);
        run_instr(5,  16'h0020, 1, 0, 1);
        run_instr(5,  16'h0020, 0, 1, 1);
        run_instr(4,  16'h0010, 0, 1, 1);
        run_instr(14, 16'h4000, 0, 0, 1);
        run_instr(-1, 16'h0000, 0, 0, 1);
        run_instr(-1, 16'h0300, 0, 0, 1);
        run_instr(13, 16'h2000, 0, 0, 0);

        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(1, 16);
            if (r == 16) begin
                if ($urandom_range(0, 1) == 0) v = '0;
                else begin
                    b0 = $urandom_range(0, 15);
                    b1 = (b0 + $urandom_range(1, 15)) % 16;
                    v  = 16'($urandom) | (16'd1 << b0) | (16'd1 << b1);
                end
                run_instr(-1, v, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            end else begin
                v = 16'd1 << r;
                run_instr(r, v, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end

        // Reset asserted in movc EX2.
        run_instr(1, 16'h0002, 0, 0, 0);
        @(negedge clk);
        instr = 16'h2000; start = 1'b1; run = 1'b1;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("movc_ex2", 32'(obs0), 32'(exp_vec(13, 4, 0, 0)));
        rst_n = 1'b0;
        #1;
        check_eq("async_rst0", 32'(obs0), 32'd0);
        check_eq("async_rst1", 32'(obs1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst0", 32'(obs0), 32'd0);
        check_eq("post_rst1", 32'(obs1), 32'd0);

        // Halt: dut0 stays halted, dut1 resumes on the start pulse at j=3.
        instr = 16'h0001; start = 1'b1; run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            check_eq($sformatf("halt_fetch cyc%0d", k), 32'(obs0), 32'(exp_vec(0, k, 0, 0)));
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check_eq($sformatf("halt_hold0 j%0d", j), 32'(obs0), 32'(exp_vec(0, 3, 0, 0)));
            check_eq($sformatf("halt_res1 j%0d", j), 32'(obs1),
                     32'(exp_vec(0, (j < 4) ? 3 : j - 4, 0, 0)));
            start = (j == 3 || j == 5) ? 1'b1 : 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
